// File: rtl/edge_line_scheduler.sv
// rtl/edge_line_scheduler.sv - line-buffer write/read window scheduler for the Sobel stage
// Ports:
//   bus_clk, rst_n                 clock, asynchronous active-low reset
//   wr_valid, wr_first, wr_ready   grayscale word handshake (wr_first marks start of frame)
//   wr_en, wr_line_sel             write strobe and target ring line
//   rd_ready, rd_valid, rd_en      window word handshake
//   rd_top, rd_mid, rd_bot         ring lines for window rows 0/1/2
//   rd_last_pixel                  final window word of the frame
//   line_full                      per-line complete-row status
//   frame_busy, err                frame in progress, sticky protocol error
module edge_line_scheduler #(
  parameter int FRAME_WIDTH  = 640,
  parameter int PIX_PER_WORD = 4,
  parameter int FRAME_HEIGHT = 480
) (
  input  logic       bus_clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  input  logic       wr_first,
  output logic       wr_ready,
  output logic       wr_en,
  output logic [1:0] wr_line_sel,
  input  logic       rd_ready,
  output logic       rd_valid,
  output logic       rd_en,
  output logic [1:0] rd_top,
  output logic [1:0] rd_mid,
  output logic [1:0] rd_bot,
  output logic       rd_last_pixel,
  output logic [3:0] line_full,
  output logic       frame_busy,
  output logic       err
);

  localparam int W  = FRAME_WIDTH / PIX_PER_WORD;
  localparam int H  = FRAME_HEIGHT;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  // Row counters must hold H (rows_done) plus the +3 ring look-ahead.
  localparam int RW = $clog2(H + 4) + 1;

  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);
  localparam logic [RW-1:0] ROWS_ALL = RW'(H);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wr_col_q, wr_col_d;
  logic [CW-1:0] rd_col_q, rd_col_d;
  logic [RW-1:0] wr_row_q, wr_row_d;
  logic [RW-1:0] rd_row_q, rd_row_d;
  logic [RW-1:0] rows_done_q, rows_done_d;
  logic [RW-1:0] rows_rel_q, rows_rel_d;
  logic [3:0]    line_full_q, line_full_d;
  logic          frame_busy_q, frame_busy_d;
  logic          err_q, err_d;

  logic          active;
  logic          run_ready;
  logic          sof_err;
  logic [RW-1:0] rd_prev_row;
  logic [RW-1:0] rd_next_row;
  logic          rd_row_end;
  logic          rd_last;
  logic          release_row;

  assign active = (state_q == S_RUN) || (state_q == S_DRAIN);

  // Ring look-ahead: row k may be written only once row k-4 has been released.
  assign run_ready = (state_q == S_RUN) && (rows_done_q != ROWS_ALL) &&
                     (wr_row_q <= rows_rel_q + RW'(3));

  // A stray start-of-frame inside a frame is swallowed (ready held high) and flagged.
  assign sof_err  = active && wr_valid && wr_first;
  assign wr_ready = (state_q == S_IDLE) || run_ready || (active && wr_first);
  assign wr_en    = wr_valid && ((state_q == S_IDLE) ? wr_first : (run_ready && !wr_first));
  assign wr_line_sel = wr_row_q[1:0];

  // Border replication: clamp neighbour rows to the frame.
  assign rd_prev_row = (rd_row_q == '0) ? '0 : rd_row_q - RW'(1);
  assign rd_next_row = (rd_row_q == ROW_LAST) ? ROW_LAST : rd_row_q + RW'(1);

  assign rd_valid = active && (rows_done_q > rd_next_row);
  assign rd_en    = rd_valid && rd_ready;
  assign rd_top   = active ? rd_prev_row[1:0] : 2'd0;
  assign rd_mid   = active ? rd_row_q[1:0]    : 2'd0;
  assign rd_bot   = active ? rd_next_row[1:0] : 2'd0;

  assign rd_row_end    = rd_en && (rd_col_q == COL_LAST);
  assign rd_last       = rd_row_end && (rd_row_q == ROW_LAST);
  assign rd_last_pixel = rd_last;
  // Finishing row r means row r-1 is no longer needed as a top neighbour.
  assign release_row   = rd_row_end && (rd_row_q != '0) && (rd_row_q < ROW_LAST);

  assign line_full  = line_full_q;
  assign frame_busy = frame_busy_q;
  assign err        = err_q;

  always_comb begin
    state_d      = state_q;
    wr_col_d     = wr_col_q;
    rd_col_d     = rd_col_q;
    wr_row_d     = wr_row_q;
    rd_row_d     = rd_row_q;
    rows_done_d  = rows_done_q;
    rows_rel_d   = rows_rel_q;
    line_full_d  = line_full_q;
    frame_busy_d = frame_busy_q;
    err_d        = err_q;

    if (wr_en) begin
      if (wr_col_q == COL_LAST) begin
        wr_col_d    = '0;
        wr_row_d    = (wr_row_q == ROW_LAST) ? '0 : wr_row_q + RW'(1);
        rows_done_d = rows_done_q + RW'(1);
      end else begin
        wr_col_d = wr_col_q + CW'(1);
      end
    end

    if (rd_en) begin
      if (rd_col_q == COL_LAST) begin
        rd_col_d = '0;
        rd_row_d = (rd_row_q == ROW_LAST) ? '0 : rd_row_q + RW'(1);
      end else begin
        rd_col_d = rd_col_q + CW'(1);
      end
    end

    if (release_row) begin
      rows_rel_d = rows_rel_q + RW'(1);
      line_full_d[rd_prev_row[1:0]] = 1'b0;
    end
    if (wr_en && (wr_col_q == COL_LAST)) begin
      line_full_d[wr_row_q[1:0]] = 1'b1;
    end

    if (sof_err) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (wr_en) begin
          state_d      = S_RUN;
          frame_busy_d = 1'b1;
        end
      end
      S_RUN: begin
        if (rd_last) begin
          state_d = S_DONE;
        end else if (rows_done_q == ROWS_ALL) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (rd_last) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d      = S_IDLE;
        frame_busy_d = 1'b0;
        line_full_d  = '0;
        wr_col_d     = '0;
        rd_col_d     = '0;
        wr_row_d     = '0;
        rd_row_d     = '0;
        rows_done_d  = '0;
        rows_rel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge bus_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_col_q     <= '0;
      rd_col_q     <= '0;
      wr_row_q     <= '0;
      rd_row_q     <= '0;
      rows_done_q  <= '0;
      rows_rel_q   <= '0;
      line_full_q  <= '0;
      frame_busy_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_col_q     <= wr_col_d;
      rd_col_q     <= rd_col_d;
      wr_row_q     <= wr_row_d;
      rd_row_q     <= rd_row_d;
      rows_done_q  <= rows_done_d;
      rows_rel_q   <= rows_rel_d;
      line_full_q  <= line_full_d;
      frame_busy_q <= frame_busy_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_edge_line_scheduler.sv
// tb/tb_edge_line_scheduler.sv - scoreboard bench for edge_line_scheduler
module tb_edge_line_scheduler;

  localparam int FW  = 8;
  localparam int PPW = 4;
  localparam int W   = FW / PPW;
  localparam int H   = 6;
  localparam int NW  = W * H;

  logic       bus_clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_first = 1'b0;
  logic       rd_ready = 1'b0;
  logic       wr_ready, wr_en, rd_valid, rd_en, rd_last_pixel, frame_busy, err;
  logic [1:0] wr_line_sel, rd_top, rd_mid, rd_bot;
  logic [3:0] line_full;

  edge_line_scheduler #(
    .FRAME_WIDTH (FW),
    .PIX_PER_WORD(PPW),
    .FRAME_HEIGHT(H)
  ) dut (
    .bus_clk      (bus_clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_first     (wr_first),
    .wr_ready     (wr_ready),
    .wr_en        (wr_en),
    .wr_line_sel  (wr_line_sel),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .rd_en        (rd_en),
    .rd_top       (rd_top),
    .rd_mid       (rd_mid),
    .rd_bot       (rd_bot),
    .rd_last_pixel(rd_last_pixel),
    .line_full    (line_full),
    .frame_busy   (frame_busy),
    .err          (err)
  );

  always #5 bus_clk = ~bus_clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_errs++;
    $display("FAIL %s: cycle bound expired at %0t", name, $time);
  endtask

  // Reference model: frame progress as word counts; everything else derived arithmetically.
  typedef enum int {M_IDLE, M_ACT, M_DONE} mstate_t;
  mstate_t m_state;
  int      m_wc, m_rc;
  bit      m_err;
  int      m_rows_done, m_rd_row, m_rel, m_nb;
  bit      m_wr_ready, m_wr_en, m_rd_valid, m_rd_fire;
  logic [3:0] m_full;

  always_comb begin
    m_rows_done = m_wc / W;
    m_rd_row    = m_rc / W;
    m_rel       = m_rd_row - 1;
    if (m_rel < 0) m_rel = 0;
    if (m_rel > H - 2) m_rel = H - 2;
    m_full = 4'b0000;
    if (m_state != M_IDLE) begin
      for (int k = m_rel; k < m_rows_done; k++) m_full[k % 4] = 1'b1;
    end
    case (m_state)
      M_IDLE:  m_wr_ready = 1'b1;
      M_ACT:   m_wr_ready = wr_first || (m_rows_done < H && m_rows_done <= m_rel + 3);
      default: m_wr_ready = 1'b0;
    endcase
    m_wr_en = wr_valid && m_wr_ready &&
              ((m_state == M_IDLE) ? wr_first : (m_state == M_ACT && !wr_first));
    m_nb = (m_rd_row + 1 < H - 1) ? m_rd_row + 1 : H - 1;
    m_rd_valid = (m_state == M_ACT) && (m_rc < NW) && (m_rows_done > m_nb);
    m_rd_fire  = m_rd_valid && rd_ready;
  end

  always @(posedge bus_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= M_IDLE;
      m_wc    <= 0;
      m_rc    <= 0;
      m_err   <= 1'b0;
    end else begin
      if (m_wr_en) m_wc <= m_wc + 1;
      if (m_rd_fire) m_rc <= m_rc + 1;
      if (m_state == M_ACT && wr_valid && wr_first) m_err <= 1'b1;
      case (m_state)
        M_IDLE: if (m_wr_en) m_state <= M_ACT;
        M_ACT:  if (m_rd_fire && m_rc == NW - 1) m_state <= M_DONE;
        default: begin
          m_state <= M_IDLE;
          m_wc    <= 0;
          m_rc    <= 0;
        end
      endcase
    end
  end

  typedef struct packed {
    logic [1:0] top;
    logic [1:0] mid;
    logic [1:0] bot;
    logic       last;
  } win_t;
  win_t exp_q[$];
  win_t mon_w;

  // Monitor: handshake/status against the model every cycle, windows against the scoreboard.
  always @(negedge bus_clk) begin
    if (rst_n) begin
      chk("wr_ready", wr_ready, m_wr_ready);
      chk("wr_en", wr_en, m_wr_en);
      if (m_wr_en) chk("wr_line_sel", wr_line_sel, m_rows_done % 4);
      chk("rd_valid", rd_valid, m_rd_valid);
      chk("rd_en", rd_en, m_rd_fire);
      chk("line_full", line_full, m_full);
      chk("frame_busy", frame_busy, m_state != M_IDLE);
      chk("err", err, m_err);
      if (rd_en) begin
        if (exp_q.size() == 0) begin
          bound_fail("window_unexpected");
        end else begin
          mon_w = exp_q.pop_front();
          chk("rd_top", rd_top, mon_w.top);
          chk("rd_mid", rd_mid, mon_w.mid);
          chk("rd_bot", rd_bot, mon_w.bot);
          chk("rd_last_pixel", rd_last_pixel, mon_w.last);
        end
      end else begin
        chk("rd_last_quiet", rd_last_pixel, 0);
      end
    end
  end

  task automatic push_windows();
    win_t w;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        w.top  = 2'((r > 0 ? r - 1 : 0) % 4);
        w.mid  = 2'(r % 4);
        w.bot  = 2'((r < H - 1 ? r + 1 : H - 1) % 4);
        w.last = (r == H - 1) && (c == W - 1);
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic send_frame(input int p_valid, input int p_rd, input int hold_rd,
                            input bit inject, input int abort_rows);
    int left = NW;
    bit first = 1'b1;
    int cyc = 0;
    int rd_cnt = 0;
    bit injected = 1'b0;
    bit injecting;
    bit chk_bp = 1'b0;
    push_windows();
    forever begin
      @(posedge bus_clk);
      #1;
      cyc++;
      if (cyc > 2000) begin
        bound_fail("frame_timeout");
        break;
      end
      injecting = inject && !injected && !first && (left == NW / 2);
      if (injecting) begin
        wr_valid = 1'b1;
        wr_first = 1'b1;
        injected = 1'b1;
      end else begin
        wr_valid = (left > 0) && ($urandom_range(99) < p_valid);
        wr_first = first;
      end
      rd_ready = (cyc > hold_rd) && ($urandom_range(99) < p_rd);
      @(negedge bus_clk);
      if (injecting) begin
        chk("err_word_wr_en", wr_en, 0);
        chk("err_word_ready", wr_ready, 1);
      end
      if (hold_rd > 0 && cyc == hold_rd) begin
        chk("bp_line_full", line_full, 4'hF);
        chk("bp_wr_ready", wr_ready, 0);
      end
      if (chk_bp) begin
        chk("bp_resume_ready", wr_ready, 1);
        chk("bp_resume_sel", wr_line_sel, 0);
        chk_bp = 1'b0;
      end
      if (m_wr_en) begin
        left--;
        first = 1'b0;
      end
      if (m_rd_fire) begin
        rd_cnt++;
        if (hold_rd > 0 && rd_cnt == 4) chk_bp = 1'b1;
      end
      if (abort_rows > 0 && m_rows_done >= abort_rows) break;
      if (left == 0 && !first && m_state == M_IDLE) break;
    end
    #1;
    wr_valid = 1'b0;
    wr_first = 1'b0;
    rd_ready = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_wr_ready"}, wr_ready, 1);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_line_full"}, line_full, 0);
    chk({tag, "_frame_busy"}, frame_busy, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_rd_last"}, rd_last_pixel, 0);
    chk({tag, "_sel"}, {wr_line_sel, rd_top, rd_mid, rd_bot}, 0);
  endtask

  initial begin
    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #2 check_reset_values("reset");
    repeat (2) @(negedge bus_clk);
    #1 rst_n = 1'b1;

    // Resync: stray words in IDLE are consumed without starting a frame.
    repeat (3) begin
      @(posedge bus_clk);
      #1;
      wr_valid = 1'b1;
      wr_first = 1'b0;
      @(negedge bus_clk);
      chk("resync_wr_en", wr_en, 0);
      chk("resync_wr_ready", wr_ready, 1);
      chk("resync_busy", frame_busy, 0);
    end
    #1 wr_valid = 1'b0;

    // Basic frame, full throughput.
    send_frame(100, 100, 0, 1'b0, 0);
    chk("basic_sb_empty", exp_q.size(), 0);

    // Backpressure: reads held off until the ring fills.
    send_frame(100, 100, 12, 1'b0, 0);
    chk("bp_sb_empty", exp_q.size(), 0);

    // Randomized traffic.
    for (int i = 0; i < 4; i++) begin
      send_frame($urandom_range(30, 100), $urandom_range(20, 100), 0, 1'b0, 0);
      chk("rand_sb_empty", exp_q.size(), 0);
    end

    // Protocol error mid-frame; frame still completes and err sticks.
    send_frame(100, 60, 0, 1'b1, 0);
    chk("err_sb_empty", exp_q.size(), 0);
    repeat (3) @(negedge bus_clk);
    chk("err_sticky", err, 1);

    // Reset mid-frame after row 2 has been written.
    send_frame(100, 0, 0, 1'b0, 3);
    @(posedge bus_clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midreset");
    exp_q.delete();
    @(negedge bus_clk);
    #1 rst_n = 1'b1;

    send_frame(100, 100, 0, 1'b0, 0);
    chk("post_reset_sb_empty", exp_q.size(), 0);
    send_frame(70, 50, 0, 1'b0, 0);
    chk("final_sb_empty", exp_q.size(), 0);

    repeat (2) @(negedge bus_clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/edge_line_scheduler.md
Name: edge_line_scheduler

Overview:
- Sequences the 4-line ring buffer that sits between the grayscale converter and the Sobel convolution stage of the edge detector.
- Tracks which ring line each incoming grayscale row is written to and when each line is released.
- Issues 3-row window selects to the convolution stage, replicating the top and bottom border rows.
- Flags the final window word of each frame.

Parameters:
- FRAME_WIDTH, 640: pixels per row.
- PIX_PER_WORD, 4: grayscale pixels per 32-bit word. W = FRAME_WIDTH/PIX_PER_WORD words per row; must divide exactly.
- FRAME_HEIGHT, 480: rows per frame. Must be >= 2.

Ports:
- bus_clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  grayscale word available
- wr_first  in  1  qualifies wr_valid: first word of a frame
- wr_ready  out  1  scheduler accepts the word
- wr_en  out  1  write strobe to the line buffer (= wr_valid & wr_ready, frame words only)
- wr_line_sel  out  2  ring line targeted by wr_en
- rd_ready  in  1  convolution stage can take a window word
- rd_valid  out  1  window word available
- rd_en  out  1  read strobe (= rd_valid & rd_ready)
- rd_top, rd_mid, rd_bot  out  2 each  ring line index for window rows 0/1/2
- rd_last_pixel  out  1  high with the rd_en of the final window word of the frame
- line_full  out  4  per-line complete-row status
- frame_busy  out  1  high from SOF accept until the last window read
- err  out  1  sticky protocol error

Behaviour:
Async reset (rst_n low, immediate):
- State IDLE; all counters 0; line_full = 0.
- rd_valid, rd_en, wr_en, rd_last_pixel, frame_busy, err = 0.
- wr_line_sel, rd_top, rd_mid, rd_bot = 0.
- wr_ready = 1 (IDLE).

Timing rules:
- wr_ready and rd_valid derive from registered state only. No combinational path from wr_valid to wr_ready, or from rd_ready to rd_valid.

Ring mapping:
- Input row k is written to line k mod 4.
- wr_line_sel = wr_row[1:0].

Counters:
- wr_col 0..W-1 and wr_row 0..H-1 advance on wr_en.
- rd_col 0..W-1 and rd_row 0..H-1 advance on rd_en. Column wraps to 0 and row increments at W-1.
- rows_done counts completed input rows.
- rows_rel counts released input rows.

FSM:
- IDLE:
  - wr_ready = 1.
  - wr_valid with wr_first=0: word consumed and dropped (wr_en = 0), to resync.
  - wr_valid with wr_first=1: wr_en = 1 for that word, frame_busy set, go to RUN.
- RUN:
  - wr_ready = (wr_row <= rows_rel + 3).
  - When rows_done == H, go to DRAIN.
- DRAIN:
  - wr_ready = 0.
  - Reading continues. On the rd_en of the last word, go to DONE.
- DONE (1 cycle):
  - line_full cleared, frame_busy cleared, all counters 0, go to IDLE.

Line status:
- line_full[k mod 4] sets on the wr_en of the last word (wr_col = W-1) of row k.

Window:
- rd_valid = (state RUN or DRAIN) & (rows_done > min(rd_row+1, H-1)).
- rd_top = line(max(rd_row-1, 0)).
- rd_mid = line(rd_row).
- rd_bot = line(min(rd_row+1, H-1)).
- line(j) = j mod 4.

Release:
- On the rd_en with rd_col = W-1 and 1 <= rd_row <= H-2, input row rd_row-1 is released: rows_rel++ and its line_full bit cleared.
- The remaining lines are freed in DONE.

Simultaneous events:
- A line released in cycle t is writable from cycle t+1 (registered).
- A line completing and being read in the same cycle: completion is visible to rd_valid at t+1.

rd_last_pixel:
- High on the rd_en with rd_row = H-1 and rd_col = W-1.

err:
- Set when wr_valid & wr_first occurs in RUN or DRAIN. That word is dropped and wr_ready is held 1 for it.
- The frame continues.
- err is cleared only by reset.

Latency:
- The first rd_valid occurs 1 cycle after the wr_en of the last word of row 1.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with no clock edge -> all outputs listed above go to reset values immediately; wr_ready = 1.
- Basic frame (FRAME_WIDTH=8, PIX_PER_WORD=4, H=4, rd_ready=1, wr_valid=1 continuous):
  - Write rows 0 and 1 -> rd_valid rises 1 cycle after the 4th wr_en, with top/mid/bot = 0/0/1.
  - Output row 3 -> 2/3/3.
  - rd_last_pixel on the 8th rd_en.
  - frame_busy falls 2 cycles later.
- Backpressure (H=6, rd_ready=0):
  - After 8 wr_en -> line_full = 4'b1111, wr_ready = 0.
  - Raise rd_ready -> wr_ready returns 1 cycle after the 4th rd_en (row 0 released), with wr_line_sel = 0 for row 4.
- Resync: 3 words with wr_first=0 in IDLE -> wr_ready = 1, wr_en = 0, frame_busy = 0. Next wr_first word -> wr_en = 1, frame_busy = 1.
- Protocol error: wr_first=1 during RUN -> err = 1 and stays 1, that word wr_en = 0, frame completes with correct rd_last_pixel.
- Reset mid-frame: rst_n low after row 2 is written -> line_full = 0, rd_valid = 0. A new frame after release behaves exactly as the basic frame.
